// File: rtl/ysyx_041461_if_fetch.sv
// rtl/ysyx_041461_if_fetch.sv - instruction fetch stage: PC owner, single-outstanding 64-bit read, IF/ID outputs
module ysyx_041461_if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_3000_0000,
    parameter logic [3:0]  TRAP_NOP = 4'h0,
    parameter logic [3:0]  TRAP_IAF = 4'h1,
    parameter logic [3:0]  TRAP_IAM = 4'h2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_accept,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_arvalid,
    output logic [63:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        if_valid_out,
    output logic [3:0]  if_trap_out,
    output logic [31:0] if_inst_out,
    output logic [63:0] if_pc_out
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic        kill, kill_nxt;
    logic        ar_hold, ar_hold_nxt;
    logic [63:0] ar_addr, ar_addr_nxt;
    logic        load_out;
    logic [3:0]  trap_nxt;
    logic [31:0] inst_nxt;
    logic        misaligned;

    assign misaligned   = (pc[1:0] != 2'b00);
    assign if_valid_out = (state == HOLD);
    // A redirect during an unaccepted address phase moves pc, so the pending
    // address is frozen in ar_addr until the handshake completes.
    assign imem_araddr  = ar_hold ? ar_addr : {pc[63:3], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            ar_hold     <= 1'b0;
            ar_addr     <= 64'd0;
            if_trap_out <= TRAP_NOP;
            if_inst_out <= 32'd0;
            if_pc_out   <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            kill    <= kill_nxt;
            ar_hold <= ar_hold_nxt;
            ar_addr <= ar_addr_nxt;
            if (load_out) begin
                if_trap_out <= trap_nxt;
                if_inst_out <= inst_nxt;
                if_pc_out   <= pc;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_nxt     = kill;
        ar_hold_nxt  = ar_hold;
        ar_addr_nxt  = ar_addr;
        load_out     = 1'b0;
        trap_nxt     = TRAP_NOP;
        inst_nxt     = 32'd0;
        imem_arvalid = 1'b0;
        imem_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end
                state_nxt = REQ;
            end
            REQ: begin
                if (ar_hold || !misaligned) begin
                    imem_arvalid = 1'b1;
                    if (imem_arready) begin
                        state_nxt   = RESP;
                        ar_hold_nxt = 1'b0;
                        if (redirect_valid) begin
                            kill_nxt = 1'b1;
                            pc_nxt   = redirect_pc;
                        end
                    end else if (redirect_valid) begin
                        kill_nxt    = 1'b1;
                        pc_nxt      = redirect_pc;
                        ar_hold_nxt = 1'b1;
                        if (!ar_hold) begin
                            ar_addr_nxt = {pc[63:3], 3'b000};
                        end
                    end
                end else if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else begin
                    load_out  = 1'b1;
                    trap_nxt  = TRAP_IAM;
                    state_nxt = HOLD;
                end
            end
            RESP: begin
                imem_rready = 1'b1;
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    if (imem_rvalid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        load_out  = 1'b1;
                        state_nxt = HOLD;
                        if (imem_rresp != 2'b00) begin
                            trap_nxt = TRAP_IAF;
                        end else begin
                            inst_nxt = pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (id_accept) begin
                    pc_nxt    = pc + 64'd4;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_041461_if_fetch.sv
// tb/tb_ysyx_041461_if_fetch.sv - self-checking bench for the instruction fetch stage
module tb_ysyx_041461_if_fetch;

    logic        clk;
    logic        rst;
    logic        id_accept;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_arvalid;
    logic [63:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rready;
    logic        if_valid_out;
    logic [3:0]  if_trap_out;
    logic [31:0] if_inst_out;
    logic [63:0] if_pc_out;

    ysyx_041461_if_fetch dut (
        .clk(clk), .rst(rst), .id_accept(id_accept),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(imem_arready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
        .imem_rready(imem_rready), .if_valid_out(if_valid_out), .if_trap_out(if_trap_out),
        .if_inst_out(if_inst_out), .if_pc_out(if_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] + 32'h1234_5678};
    endfunction

    function automatic bit mem_err(input logic [63:0] a);
        return a[7:3] == 5'h1F;
    endfunction

    function automatic logic [3:0] model_trap(input logic [63:0] p);
        if (p[1:0] != 2'b00) return 4'h2;
        if (mem_err({p[63:3], 3'b000})) return 4'h1;
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_inst(input logic [63:0] p);
        logic [63:0] w;
        w = mem_word({p[63:3], 3'b000});
        if (model_trap(p) != 4'h0) return 32'd0;
        return p[2] ? w[63:32] : w[31:0];
    endfunction

    // Memory responder: one slave, answers each accepted address after a latency.
    bit          ovr_en;
    logic [63:0] ovr_data;
    logic [1:0]  ovr_resp;
    bit          ar_rand;
    bit          lat_rand;
    int          mem_lat;
    bit          pend;
    int          dly;
    logic [63:0] paddr;
    bit          ar_wait;
    logic [63:0] ar_wait_addr;
    int          n_rsp;

    always @(negedge clk) begin
        if (rst) begin
            pend         = 1'b0;
            ar_wait      = 1'b0;
            imem_rvalid  = 1'b0;
            imem_arready = 1'b0;
        end else begin
            if (ar_wait)
                chk(imem_arvalid && imem_araddr == ar_wait_addr, "araddr_stable", imem_araddr, ar_wait_addr);
            imem_rvalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ovr_en ? ovr_data : mem_word(paddr);
                    imem_rresp  = ovr_en ? ovr_resp : (mem_err(paddr) ? 2'b10 : 2'b00);
                    if (imem_rready) begin
                        pend = 1'b0;
                        n_rsp++;
                    end
                end else begin
                    dly--;
                end
            end
            imem_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (imem_arvalid) begin
                chk(!pend, "one_outstanding", 64'(pend), 64'd0);
                if (imem_arready) begin
                    pend  = 1'b1;
                    paddr = imem_araddr;
                    dly   = lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
                end
            end
            ar_wait      = imem_arvalid && !imem_arready;
            ar_wait_addr = imem_araddr;
        end
    end

    task automatic wait_valid(input int maxc, input string name);
        int k = 0;
        while (!if_valid_out && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(if_valid_out, {name, "_valid"}, 64'(if_valid_out), 64'd1);
    endtask

    task automatic check_out(input string name, input logic [63:0] pc, input logic [31:0] inst, input logic [3:0] trap);
        chk(if_pc_out == pc, {name, "_pc"}, if_pc_out, pc);
        chk(if_inst_out == inst, {name, "_inst"}, 64'(if_inst_out), 64'(inst));
        chk(if_trap_out == trap, {name, "_trap"}, 64'(if_trap_out), 64'(trap));
    endtask

    typedef struct {
        bit          redir;
        bit          acc;
        logic [63:0] target;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
        logic [3:0]  exp_trap;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0x0, expected 0x1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] tgt;
        int          rsp0;
        int          idle;
        int          deliveries;
        bit          acc;
        bit          rd;
        bit          seen;

        vecs[0] = '{1, 0, 64'h1000_0000, 64'h1111_2222_3333_4444, 2'b00, 64'h1000_0000, 32'h3333_4444, 4'h0};
        vecs[1] = '{1, 0, 64'h1000_0004, 64'h1111_2222_3333_4444, 2'b00, 64'h1000_0004, 32'h1111_2222, 4'h0};
        vecs[2] = '{1, 0, 64'h1000_000C, 64'h1111_2222_3333_4444, 2'b01, 64'h1000_000C, 32'h0, 4'h1};
        vecs[3] = '{1, 0, 64'h1000_0001, 64'h1111_2222_3333_4444, 2'b00, 64'h1000_0001, 32'h0, 4'h2};
        vecs[4] = '{1, 0, 64'h2000_0003, 64'h1111_2222_3333_4444, 2'b11, 64'h2000_0003, 32'h0, 4'h2};
        vecs[5] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hCAFE_F00D_0BAD_BEEF, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_F00D, 4'h0};
        vecs[6] = '{0, 1, 64'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0, 32'h89AB_CDEF, 4'h0};
        vecs[7] = '{1, 1, 64'h5000_0000, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h5000_0000, 32'h89AB_CDEF, 4'h0};
        vecs[8] = '{0, 1, 64'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h5000_0004, 32'h0123_4567, 4'h0};

        rst = 1'b1; id_accept = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        ovr_en = 1'b1; ovr_data = 64'h0000_0013_0010_0093; ovr_resp = 2'b00;
        ar_rand = 1'b0; lat_rand = 1'b0; mem_lat = 0; n_rsp = 0;
        imem_rdata = 64'd0; imem_rresp = 2'b00;
        repeat (2) @(negedge clk);
        chk(!if_valid_out, "rst_valid", 64'(if_valid_out), 64'd0);
        check_out("rst", 64'h3000_0000, 32'd0, 4'h0);
        chk(!imem_arvalid, "rst_arvalid", 64'(imem_arvalid), 64'd0);
        chk(!imem_rready, "rst_rready", 64'(imem_rready), 64'd0);

        // T1: zero-wait first fetch, checking latency cycle by cycle
        rst = 1'b0;
        @(negedge clk);
        chk(imem_arvalid, "t1_arvalid", 64'(imem_arvalid), 64'd1);
        chk(imem_araddr == 64'h3000_0000, "t1_araddr", imem_araddr, 64'h3000_0000);
        @(negedge clk);
        chk(!if_valid_out, "t1_early_valid", 64'(if_valid_out), 64'd0);
        chk(imem_rready, "t1_rready", 64'(imem_rready), 64'd1);
        @(negedge clk);
        chk(if_valid_out, "t1_valid", 64'(if_valid_out), 64'd1);
        check_out("t1", 64'h3000_0000, 32'h0010_0093, 4'h0);

        // T2: hold stable while ID stalls, then advance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(if_valid_out && !imem_arvalid, "t2_hold", {if_valid_out, imem_arvalid}, 64'h2);
            check_out("t2_hold", 64'h3000_0000, 32'h0010_0093, 4'h0);
        end
        id_accept = 1'b1;
        @(negedge clk);
        id_accept = 1'b0;
        chk(imem_arvalid && imem_araddr == 64'h3000_0000, "t2_araddr", imem_araddr, 64'h3000_0000);
        wait_valid(10, "t2");
        check_out("t2", 64'h3000_0004, 32'h0000_0013, 4'h0);

        // T3: error response
        ovr_resp = 2'b10;
        id_accept = 1'b1;
        @(negedge clk);
        id_accept = 1'b0;
        wait_valid(10, "t3");
        check_out("t3", 64'h3000_0008, 32'd0, 4'h1);
        ovr_resp = 2'b00;

        // T4: redirect in HOLD to a misaligned target
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk(!if_valid_out && !imem_arvalid, "t4_drop", {if_valid_out, imem_arvalid}, 64'h0);
        @(negedge clk);
        chk(if_valid_out && !imem_arvalid, "t4_valid", {if_valid_out, imem_arvalid}, 64'h2);
        check_out("t4", 64'h8000_0002, 32'd0, 4'h2);

        // T5: redirect while waiting for the response; stale data must be dropped
        ovr_en = 1'b0; mem_lat = 2;
        redirect_valid = 1'b1; redirect_pc = 64'h4000_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 5 && !imem_rready; k++) @(negedge clk);
        chk(imem_rready, "t5_in_resp", 64'(imem_rready), 64'd1);
        rsp0 = n_rsp;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            chk(!if_valid_out, "t5_no_valid", 64'(if_valid_out), 64'd0);
            seen = imem_arvalid;
            if (!seen) @(negedge clk);
        end
        chk(n_rsp > rsp0, "t5_stale_rsp", 64'(n_rsp), 64'(rsp0 + 1));
        chk(imem_arvalid && imem_araddr == 64'h8000_0000, "t5_araddr", imem_araddr, 64'h8000_0000);
        wait_valid(10, "t5");
        check_out("t5", 64'h8000_0000, model_inst(64'h8000_0000), 4'h0);

        // T6: reset in the middle of a response wait
        mem_lat = 3;
        id_accept = 1'b1;
        @(negedge clk);
        id_accept = 1'b0;
        for (int k = 0; k < 5 && !imem_rready; k++) @(negedge clk);
        chk(imem_rready, "t6_in_resp", 64'(imem_rready), 64'd1);
        rst = 1'b1;
        #1;
        chk(!if_valid_out && !imem_rready && !imem_arvalid, "t6_rst_ctl",
            {if_valid_out, imem_rready, imem_arvalid}, 64'h0);
        chk(if_pc_out == 64'h3000_0000, "t6_rst_pc", if_pc_out, 64'h3000_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;
        for (int k = 0; k < 5 && !imem_arvalid; k++) @(negedge clk);
        chk(imem_arvalid && imem_araddr == 64'h3000_0000, "t6_araddr", imem_araddr, 64'h3000_0000);
        wait_valid(10, "t6");
        check_out("t6", 64'h3000_0000, model_inst(64'h3000_0000), 4'h0);

        // Directed vector table, each starting from HOLD
        ovr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].target;
            id_accept      = vecs[i].acc;
            ovr_data       = vecs[i].data;
            ovr_resp       = vecs[i].resp;
            @(negedge clk);
            redirect_valid = 1'b0;
            id_accept      = 1'b0;
            chk(!if_valid_out, $sformatf("vec%0d_drop", i), 64'(if_valid_out), 64'd0);
            wait_valid(10, $sformatf("vec%0d", i));
            check_out($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_trap);
        end

        // Random traffic against a PC-sequence model
        ovr_en = 1'b0; ar_rand = 1'b1; lat_rand = 1'b1;
        exp_pc = 64'h6000_0000;
        redirect_valid = 1'b1; redirect_pc = exp_pc;
        @(negedge clk);
        idle = 0;
        deliveries = 0;
        for (int c = 0; c < 4000; c++) begin
            acc = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = 64'h7000_0000 + 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            id_accept = acc; redirect_valid = rd; redirect_pc = tgt;
            if (if_valid_out && acc) begin
                check_out("rand", exp_pc, model_inst(exp_pc), model_trap(exp_pc));
                deliveries++;
                idle = 0;
            end else begin
                idle++;
            end
            if (rd) exp_pc = tgt;
            else if (if_valid_out && acc) exp_pc = exp_pc + 64'd4;
            if (idle > 60) begin
                chk(1'b0, "rand_progress", 64'(idle), 64'd60);
                break;
            end
            @(negedge clk);
        end
        id_accept = 1'b0; redirect_valid = 1'b0;
        chk(deliveries > 100, "rand_deliveries", 64'(deliveries), 64'd101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
